// File: rtl/i2c_calc_pkg.sv
// Shared types and constants for the I2C calculator target: FSM states,
// register map indices and the read-side register multiplexer.
package i2c_calc_pkg;

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      PTR,
      PTR_ACK,
      WDATA,
      WDATA_ACK,
      RDATA,
      RACK,
      IGNORE
   } state_t;

   localparam logic [2:0] REG_OP    = 3'd0;
   localparam logic [2:0] REG_A     = 3'd1;
   localparam logic [2:0] REG_B     = 3'd2;
   localparam logic [2:0] REG_RES_L = 3'd3;
   localparam logic [2:0] REG_RES_H = 3'd4;

   localparam logic [7:0] READ_FILL = 8'hFF;

   // Bit counter values used inside the three ACK states.
   localparam logic [3:0] BIT_ACK_DRIVE = 4'd8;
   localparam logic [3:0] BIT_ACK_DONE  = 4'd9;

   function automatic logic [7:0] read_mux(
      input logic [2:0]  idx,
      input logic [1:0]  op,
      input logic [7:0]  a,
      input logic [7:0]  b,
      input logic [15:0] shadow
   );
      logic [7:0] v;
      case (idx)
         REG_OP:    v = {6'b0, op};
         REG_A:     v = a;
         REG_B:     v = b;
         REG_RES_L: v = shadow[7:0];
         REG_RES_H: v = shadow[15:8];
         default:   v = READ_FILL;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA input synchronizer with SCL edge and START/STOP condition detection.
// All outputs are valid SYNC_STAGES+1 clocks after the pad change.
module i2c_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_scl,
   input  logic i_sda,
   output logic o_scl_rise,
   output logic o_scl_fall,
   output logic o_start,
   output logic o_stop,
   output logic o_sda
);

   logic [SYNC_STAGES-1:0] r_scl_sync;
   logic [SYNC_STAGES-1:0] r_sda_sync;
   logic                   r_scl_d;
   logic                   r_sda_d;
   logic                   w_scl;
   logic                   w_sda;

   // Flops reset to the idle (released, high) bus level so no false edge appears.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_scl_sync <= '1;
         r_sda_sync <= '1;
         r_scl_d    <= 1'b1;
         r_sda_d    <= 1'b1;
      end else begin
         r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
         r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
         r_scl_d    <= w_scl;
         r_sda_d    <= w_sda;
      end
   end

   assign w_scl      = r_scl_sync[SYNC_STAGES-1];
   assign w_sda      = r_sda_sync[SYNC_STAGES-1];
   assign o_sda      = w_sda;
   assign o_scl_rise = w_scl & ~r_scl_d;
   assign o_scl_fall = ~w_scl & r_scl_d;
   assign o_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
   assign o_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

endmodule

// File: rtl/i2c_calc_target.sv
// I2C target front end for the calculator: pointer-addressed register file
// (op_code, operand_a, operand_b) plus a coherent 16-bit result read shadow.
module i2c_calc_target #(
   parameter logic [6:0] TARGET_ADDR = 7'h2A,
   parameter int         SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ena,
   input  logic        scl_in,
   input  logic        sda_in,
   output logic        sda_oe,
   output logic [1:0]  op_code,
   output logic [7:0]  operand_a,
   output logic [7:0]  operand_b,
   input  logic [15:0] result,
   output logic        cfg_strobe,
   output logic        busy
);
   import i2c_calc_pkg::*;

   logic w_rise, w_fall, w_start, w_stop, w_sda;

   i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_scl      (scl_in),
      .i_sda      (sda_in),
      .o_scl_rise (w_rise),
      .o_scl_fall (w_fall),
      .o_start    (w_start),
      .o_stop     (w_stop),
      .o_sda      (w_sda)
   );

   state_t      r_state, w_state_next;
   logic [3:0]  r_bit_cnt, w_bit_cnt_next;
   logic [7:0]  r_shift, w_shift_next;
   logic [7:0]  r_ptr, w_ptr_next;
   logic [1:0]  r_op, w_op_next;
   logic [7:0]  r_a, w_a_next;
   logic [7:0]  r_b, w_b_next;
   logic [15:0] r_shadow, w_shadow_next;
   logic        r_rw, w_rw_next;
   logic        r_sda_oe, w_sda_oe_next;
   logic        r_busy, w_busy_next;
   logic        r_strobe, w_strobe_next;
   logic [7:0]  w_byte;
   logic [7:0]  w_rd_byte;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_ptr     <= '0;
         r_op      <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_shadow  <= '0;
         r_rw      <= 1'b0;
         r_sda_oe  <= 1'b0;
         r_busy    <= 1'b0;
         r_strobe  <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_bit_cnt <= w_bit_cnt_next;
         r_shift   <= w_shift_next;
         r_ptr     <= w_ptr_next;
         r_op      <= w_op_next;
         r_a       <= w_a_next;
         r_b       <= w_b_next;
         r_shadow  <= w_shadow_next;
         r_rw      <= w_rw_next;
         r_sda_oe  <= w_sda_oe_next;
         r_busy    <= w_busy_next;
         r_strobe  <= w_strobe_next;
      end
   end

   assign w_byte    = {r_shift[6:0], w_sda};
   assign w_rd_byte = read_mux(r_ptr[2:0], r_op, r_a, r_b, r_shadow);

   always_comb begin
      w_state_next   = r_state;
      w_bit_cnt_next = r_bit_cnt;
      w_shift_next   = r_shift;
      w_ptr_next     = r_ptr;
      w_op_next      = r_op;
      w_a_next       = r_a;
      w_b_next       = r_b;
      w_shadow_next  = r_shadow;
      w_rw_next      = r_rw;
      w_sda_oe_next  = r_sda_oe;
      w_busy_next    = r_busy;
      w_strobe_next  = 1'b0;

      if (!ena) begin
         w_state_next  = IDLE;
         w_sda_oe_next = 1'b0;
         w_busy_next   = 1'b0;
      end else if (w_start) begin
         w_state_next   = ADDR;
         w_bit_cnt_next = '0;
         w_sda_oe_next  = 1'b0;
         w_busy_next    = 1'b0;
      end else if (w_stop) begin
         w_state_next  = IDLE;
         w_sda_oe_next = 1'b0;
         w_busy_next   = 1'b0;
      end else if (w_rise) begin
         case (r_state)
            ADDR, PTR, WDATA: begin
               w_shift_next   = w_byte;
               w_bit_cnt_next = r_bit_cnt + 4'd1;
               if (r_bit_cnt == 4'd7) begin
                  w_bit_cnt_next = BIT_ACK_DRIVE;
                  if (r_state == ADDR) begin
                     if (w_byte[7:1] == TARGET_ADDR) begin
                        w_state_next = ADDR_ACK;
                        w_busy_next  = 1'b1;
                        w_rw_next    = w_byte[0];
                        if (w_byte[0])
                           w_shadow_next = result;
                     end else begin
                        w_state_next = IGNORE;
                     end
                  end else if (r_state == PTR) begin
                     w_ptr_next   = w_byte;
                     w_state_next = PTR_ACK;
                  end else begin
                     // Data byte complete: commit now, the ACK follows unconditionally.
                     w_state_next = WDATA_ACK;
                     w_ptr_next   = r_ptr + 8'd1;
                     case (r_ptr[2:0])
                        REG_OP: begin w_op_next = w_byte[1:0]; w_strobe_next = 1'b1; end
                        REG_A:  begin w_a_next  = w_byte;      w_strobe_next = 1'b1; end
                        REG_B:  begin w_b_next  = w_byte;      w_strobe_next = 1'b1; end
                        default: ;
                     endcase
                  end
               end
            end
            ADDR_ACK, PTR_ACK, WDATA_ACK: begin
               if (r_bit_cnt == BIT_ACK_DRIVE)
                  w_bit_cnt_next = BIT_ACK_DONE;
            end
            RDATA: w_bit_cnt_next = r_bit_cnt + 4'd1;
            RACK: begin
               if (!w_sda) begin
                  w_ptr_next     = r_ptr + 8'd1;
                  w_bit_cnt_next = BIT_ACK_DONE;
               end else begin
                  w_state_next = IGNORE;
               end
            end
            default: ;
         endcase
      end else if (w_fall) begin
         case (r_state)
            ADDR_ACK, PTR_ACK, WDATA_ACK: begin
               if (r_bit_cnt == BIT_ACK_DRIVE) begin
                  w_sda_oe_next = 1'b1;
               end else if (r_bit_cnt == BIT_ACK_DONE) begin
                  w_bit_cnt_next = '0;
                  w_sda_oe_next  = 1'b0;
                  if (r_state == ADDR_ACK && r_rw) begin
                     w_state_next  = RDATA;
                     w_sda_oe_next = ~w_rd_byte[7];
                  end else if (r_state == ADDR_ACK) begin
                     w_state_next = PTR;
                  end else begin
                     w_state_next = WDATA;
                  end
               end
            end
            RDATA: begin
               if (r_bit_cnt == 4'd8) begin
                  w_sda_oe_next  = 1'b0;
                  w_bit_cnt_next = '0;
                  w_state_next   = RACK;
               end else begin
                  w_sda_oe_next = ~w_rd_byte[3'd7 - r_bit_cnt[2:0]];
               end
            end
            RACK: begin
               if (r_bit_cnt == BIT_ACK_DONE) begin
                  w_bit_cnt_next = '0;
                  w_state_next   = RDATA;
                  w_sda_oe_next  = ~w_rd_byte[7];
               end
            end
            default: ;
         endcase
      end
   end

   assign sda_oe     = r_sda_oe;
   assign op_code    = r_op;
   assign operand_a  = r_a;
   assign operand_b  = r_b;
   assign cfg_strobe = r_strobe;
   assign busy       = r_busy;

endmodule

// File: tb/tb_i2c_calc_target.sv
// Directed bit-banged I2C controller bench for i2c_calc_target.
module tb_i2c_calc_target;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ena = 1'b1;
   logic        scl = 1'b1;
   logic        sda_m = 1'b1;
   logic [15:0] result = 16'hBEEF;
   logic        sda_bus;
   logic        sda_oe, cfg_strobe, busy;
   logic [1:0]  op_code;
   logic [7:0]  operand_a, operand_b;

   int n_checks = 0;
   int n_fail = 0;
   int strobe_cnt = 0;
   int oe_cnt = 0;

   assign sda_bus = sda_m & ~sda_oe;

   i2c_calc_target #(.TARGET_ADDR(7'h2A), .SYNC_STAGES(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .scl_in     (scl),
      .sda_in     (sda_bus),
      .sda_oe     (sda_oe),
      .op_code    (op_code),
      .operand_a  (operand_a),
      .operand_b  (operand_b),
      .result     (result),
      .cfg_strobe (cfg_strobe),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (cfg_strobe) strobe_cnt <= strobe_cnt + 1;
      if (sda_oe)     oe_cnt     <= oe_cnt + 1;
   end

   task automatic wait_q();
      repeat (5) @(negedge clk);
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; wait_q();
      scl = 1'b1;   wait_q();
      sda_m = 1'b0; wait_q();
      scl = 1'b0;   wait_q();
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; wait_q();
      scl = 1'b1;   wait_q();
      sda_m = 1'b1; wait_q();
   endtask

   task automatic write_bits(input logic [7:0] b, input int n);
      for (int i = 7; i > 7 - n; i--) begin
         sda_m = b[i]; wait_q();
         scl = 1'b1;   wait_q();
         wait_q();
         scl = 1'b0;   wait_q();
      end
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      write_bits(b, 8);
      sda_m = 1'b1; wait_q();
      scl = 1'b1;   wait_q();
      ack = sda_bus;
      wait_q();
      scl = 1'b0;   wait_q();
      $display("write 0x%02h ack=%0b", b, ack);
   endtask

   task automatic read_byte(input logic ack_bit, output logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         sda_m = 1'b1; wait_q();
         scl = 1'b1;   wait_q();
         b[i] = sda_bus;
         wait_q();
         scl = 1'b0;   wait_q();
      end
      sda_m = ack_bit; wait_q();
      scl = 1'b1;      wait_q();
      wait_q();
      scl = 1'b0;      wait_q();
      sda_m = 1'b1;
      $display("read 0x%02h master_ack=%0b", b, ack_bit);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      n_checks++; if (sda_oe !== 1'b0)     begin n_fail++; $display("FAIL reset_sda_oe got %0b exp 0", sda_oe); end
      n_checks++; if (op_code !== 2'b00)   begin n_fail++; $display("FAIL reset_op got %0h exp 0", op_code); end
      n_checks++; if (operand_a !== 8'h00) begin n_fail++; $display("FAIL reset_a got %02h exp 00", operand_a); end
      n_checks++; if (operand_b !== 8'h00) begin n_fail++; $display("FAIL reset_b got %02h exp 00", operand_b); end
      n_checks++; if (cfg_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_strobe got %0b exp 0", cfg_strobe); end
      n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy got %0b exp 0", busy); end
   endtask

   task automatic test_write_ab();
      logic [7:0] v [4];
      logic ack;
      int s0;
      v = '{8'h54, 8'h01, 8'h12, 8'h34};
      s0 = strobe_cnt;
      i2c_start();
      for (int i = 0; i < 4; i++) begin
         write_byte(v[i], ack);
         n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL wr_ab_ack%0d got %0b exp 0", i, ack); end
         if (i == 0) begin
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wr_ab_busy got %0b exp 1", busy); end
         end
      end
      i2c_stop();
      n_checks++; if (operand_a !== 8'h12) begin n_fail++; $display("FAIL wr_ab_a got %02h exp 12", operand_a); end
      n_checks++; if (operand_b !== 8'h34) begin n_fail++; $display("FAIL wr_ab_b got %02h exp 34", operand_b); end
      n_checks++; if (strobe_cnt - s0 !== 2) begin n_fail++; $display("FAIL wr_ab_strobes got %0d exp 2", strobe_cnt - s0); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_ab_busy_stop got %0b exp 0", busy); end
   endtask

   task automatic test_read_result();
      logic ack;
      logic [7:0] b0, b1;
      i2c_start();
      write_byte(8'h54, ack);
      write_byte(8'h00, ack);
      write_byte(8'h03, ack);
      n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL op_wr_ack got %0b exp 0", ack); end
      i2c_stop();
      n_checks++; if (op_code !== 2'b11) begin n_fail++; $display("FAIL op_wr got %0b exp 11", op_code); end
      result = 16'hBEEF;
      i2c_start();
      write_byte(8'h54, ack);
      write_byte(8'h03, ack);
      i2c_start();
      write_byte(8'h55, ack);
      n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rd_addr_ack got %0b exp 0", ack); end
      read_byte(1'b0, b0);
      result = 16'h1234;
      read_byte(1'b1, b1);
      i2c_stop();
      n_checks++; if (b0 !== 8'hEF) begin n_fail++; $display("FAIL rd_lo got %02h exp EF", b0); end
      n_checks++; if (b1 !== 8'hBE) begin n_fail++; $display("FAIL rd_hi_shadow got %02h exp BE", b1); end
   endtask

   task automatic test_bad_addr();
      logic ack;
      int o0;
      o0 = oe_cnt;
      i2c_start();
      write_byte(8'h56, ack);
      n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL bad_addr_ack got %0b exp 1", ack); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bad_addr_busy got %0b exp 0", busy); end
      write_byte(8'h01, ack);
      i2c_stop();
      n_checks++; if (oe_cnt - o0 !== 0) begin n_fail++; $display("FAIL bad_addr_oe got %0d cycles exp 0", oe_cnt - o0); end
      n_checks++; if (operand_a !== 8'h12 || operand_b !== 8'h34 || op_code !== 2'b11) begin
         n_fail++; $display("FAIL bad_addr_regs got %0h/%02h/%02h exp 3/12/34", op_code, operand_a, operand_b);
      end
   endtask

   task automatic test_partial_stop();
      logic ack;
      int s0;
      s0 = strobe_cnt;
      i2c_start();
      write_byte(8'h54, ack);
      write_byte(8'h02, ack);
      write_bits(8'hAA, 4);
      i2c_stop();
      n_checks++; if (operand_b !== 8'h34) begin n_fail++; $display("FAIL partial_b got %02h exp 34", operand_b); end
      n_checks++; if (strobe_cnt - s0 !== 0) begin n_fail++; $display("FAIL partial_strobe got %0d exp 0", strobe_cnt - s0); end
      i2c_start();
      write_byte(8'h54, ack);
      n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL partial_next_ack got %0b exp 0", ack); end
      write_byte(8'h02, ack);
      write_byte(8'h77, ack);
      i2c_stop();
      n_checks++; if (operand_b !== 8'h77) begin n_fail++; $display("FAIL partial_next_b got %02h exp 77", operand_b); end
   endtask

   task automatic test_ptr_read();
      logic ack;
      logic [7:0] b0, b1, b2;
      int s0;
      result = 16'hBEEF;
      i2c_start();
      write_byte(8'h54, ack);
      write_byte(8'h04, ack);
      i2c_start();
      write_byte(8'h55, ack);
      read_byte(1'b0, b0);
      read_byte(1'b0, b1);
      read_byte(1'b1, b2);
      i2c_stop();
      n_checks++; if (b0 !== 8'hBE) begin n_fail++; $display("FAIL ptr4_rd got %02h exp BE", b0); end
      n_checks++; if (b1 !== 8'hFF) begin n_fail++; $display("FAIL ptr5_rd got %02h exp FF", b1); end
      n_checks++; if (b2 !== 8'hFF) begin n_fail++; $display("FAIL ptr6_rd got %02h exp FF", b2); end
      s0 = strobe_cnt;
      i2c_start();
      write_byte(8'h54, ack);
      write_byte(8'h07, ack);
      write_byte(8'h99, ack);
      i2c_stop();
      n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL reg7_wr_ack got %0b exp 0", ack); end
      n_checks++; if (strobe_cnt - s0 !== 0) begin n_fail++; $display("FAIL reg7_strobe got %0d exp 0", strobe_cnt - s0); end
      n_checks++; if (operand_a !== 8'h12 || operand_b !== 8'h77 || op_code !== 2'b11) begin
         n_fail++; $display("FAIL reg7_regs got %0h/%02h/%02h exp 3/12/77", op_code, operand_a, operand_b);
      end
   endtask

   task automatic test_reset_mid();
      logic ack;
      int s0;
      i2c_start();
      write_byte(8'h54, ack);
      write_byte(8'h01, ack);
      i2c_start();
      write_byte(8'h55, ack);
      n_checks++; if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL mid_rd_drive got %0b exp 1", sda_oe); end
      rst_n = 1'b0;
      #1;
      n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL mid_rst_oe got %0b exp 0", sda_oe); end
      n_checks++; if (busy !== 1'b0 || cfg_strobe !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy_strobe got %0b/%0b exp 0/0", busy, cfg_strobe); end
      n_checks++; if (op_code !== 2'b00 || operand_a !== 8'h00 || operand_b !== 8'h00) begin
         n_fail++; $display("FAIL mid_rst_regs got %0h/%02h/%02h exp 0/00/00", op_code, operand_a, operand_b);
      end
      sda_m = 1'b1;
      scl = 1'b1;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      s0 = strobe_cnt;
      i2c_start();
      write_byte(8'h54, ack);
      n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL post_rst_addr_ack got %0b exp 0", ack); end
      write_byte(8'h01, ack);
      write_byte(8'h5A, ack);
      n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL post_rst_data_ack got %0b exp 0", ack); end
      i2c_stop();
      n_checks++; if (operand_a !== 8'h5A) begin n_fail++; $display("FAIL post_rst_a got %02h exp 5A", operand_a); end
      n_checks++; if (strobe_cnt - s0 !== 1) begin n_fail++; $display("FAIL post_rst_strobe got %0d exp 1", strobe_cnt - s0); end
   endtask

   initial begin
      test_reset();
      test_write_ab();
      test_read_result();
      test_bad_addr();
      test_partial_stop();
      test_ptr_read();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/i2c_calc_target.md
Name: i2c_calc_target

Overview:
I2C target (responder) front end for the calculator datapath. It decodes bus transactions from an external I2C controller and writes the opcode and operand registers that feed the calculator. It returns the 16-bit calculator result over the same bus. It sits between the chip pads (SCL/SDA via uio pins, open-drain emulated with output enable) and the calculator instance. It replaces direct parallel pin loading of operands.

Parameters:
TARGET_ADDR, 7'h2A, 7-bit I2C target address matched after START
SYNC_STAGES, 2, synchronizer flops on SCL/SDA inputs (min 2)

Ports:
clk  input  1  system clock; must be >= 10x SCL frequency
rst_n  input  1  reset; asynchronous assert, active-low
ena  input  1  block enable; low = ignore bus, release SDA, hold registers
scl_in  input  1  raw SCL pad input
sda_in  input  1  raw SDA pad input
sda_oe  output  1  1 = pull SDA low (pad output value tied 0); 0 = release
op_code  output  2  register 0 [1:0], calculator operation
operand_a  output  8  register 1
operand_b  output  8  register 2
result  input  16  calculator result, sampled into read shadow
cfg_strobe  output  1  one-cycle pulse after any ACKed data write to regs 0-2
busy  output  1  high from address match until STOP/repeated START

Behaviour:
- Reset: clk and rst_n only; rst_n is asynchronous and active-low. Reset values: sda_oe=0, op_code=0, operand_a=0, operand_b=0, cfg_strobe=0, busy=0, pointer=0, state=IDLE.
- Input conditioning: SCL and SDA each pass through SYNC_STAGES flops, then a one-cycle edge detector. Detection is delayed by SYNC_STAGES+1 clk.
- START: synced SDA falls while SCL is high. STOP: synced SDA rises while SCL is high. Both are recognised in every state, including mid-byte.
  - START (incl. repeated START) -> ADDR, bit counter cleared, sda_oe=0.
  - STOP -> IDLE, sda_oe=0, busy=0.
- Sampling: SDA is sampled on the SCL rising edge. sda_oe changes only on an SCL falling edge.
- Register map (8-bit pointer, only [2:0] decoded):
  - 0 op_code (write [1:0], read {6'b0,op_code})
  - 1 operand_a
  - 2 operand_b
  - 3 result[7:0] (read-only)
  - 4 result[15:8] (read-only)
  - 5-7 read 0xFF
  - Writes to 3-7 are ACKed and discarded.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB first. Match {TARGET_ADDR} -> ADDR_ACK. Mismatch -> IGNORE (no ACK, sda_oe stays 0 until STOP/START).
  - ADDR_ACK: sda_oe=1 for the 9th SCL pulse, set busy. The read/write bit selects the path:
    - R/W=0 -> PTR.
    - R/W=1 -> capture result into 16-bit read shadow at this ACK, then RDATA.
  - PTR: 8 bits into pointer -> PTR_ACK (always ACK) -> WDATA.
  - WDATA: 8 bits, then WDATA_ACK. On entry to WDATA_ACK, write the register at pointer, pulse cfg_strobe if pointer is 0-2, and increment pointer (wraps 255->0).
  - RDATA: drive byte at pointer MSB first. sda_oe = ~bit. The first bit is driven on the SCL falling edge that ends the preceding ACK. Regs 3/4 come from the shadow, not live result, so a two-byte read is coherent.
  - RACK: release SDA and sample the controller ACK on SCL rise. ACK(0) -> increment pointer, RDATA. NACK(1) -> IGNORE until STOP/START.
- Simultaneous events: START/STOP detection takes priority over SCL-edge processing in the same cycle. A write is committed only at its ACK; a START/STOP mid-byte discards the partial byte and does not pulse cfg_strobe.
- ena low: state forced to IDLE, sda_oe=0, registers and pointer held.
- Reset mid-transfer: SDA is released immediately (asynchronous). The block waits for the next START.
- Pointer persists across transactions; a read without a preceding pointer write uses the last pointer.

Decomposition:
- Package i2c_calc_pkg holds:
  - the state enum (IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE);
  - register index constants REG_OP=0, REG_A=1, REG_B=2, REG_RES_L=3, REG_RES_H=4;
  - READ_FILL=8'hFF.
- Sub-module i2c_line_sync: synchronizer plus SCL rise/fall and START/STOP detection, instantiated once. The FSM stays in i2c_calc_target.

Test Plan:
- Write 0x54,0x01,0x12,0x34 -> operand_a=0x12, operand_b=0x34; cfg_strobe pulses twice; ACK (SDA low) on all 4 ninth clocks.
- Write 0x54,0x00,0x03 -> op_code=2'b11; then 0x54,0x03 + repeated START, 0x55, read 2 bytes (ACK, NACK) with result=16'hBEEF -> bytes 0xEF, 0xBE; result changed to 0x1234 mid-read still yields 0xBE.
- Address 0x56 (0x2B write) -> no ACK, sda_oe stays 0 through STOP, registers unchanged.
- Write 0x54,0x02 then STOP after 4 data bits of 0xAA -> operand_b unchanged, no cfg_strobe; next START accepted normally.
- Pointer 0x04, read 3 bytes -> 0xBE(result high), 0xFF, 0xFF; write 0x54,0x07,0x99 -> ACKed, no register change, no strobe.
- Assert rst_n low while target drives SDA low in RDATA -> sda_oe=0 same cycle; all outputs at reset values; next full write transaction succeeds.
